// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order memory requests and buffers words for the decoder.
// Optional macro FETCH_MISALIGN_TRAP_EN turns a misaligned redirect into a sticky trap that halts fetch.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_8000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstd,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic        halted,
  output logic        misalign
);
  localparam int            AW    = $clog2(BUF_DEPTH);
  localparam logic [AW+1:0] DEPTH = (AW+2)'(BUF_DEPTH);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [AW:0]   cnt_q, cnt_d, out_q, out_d, drop_q, drop_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;
  logic [31:0]   buf_ins_q [BUF_DEPTH];
  logic [31:0]   buf_pc_q  [BUF_DEPTH];
  logic [31:0]   pcq_q     [BUF_DEPTH];

  logic          run, mis_hit, stop, redir, rsp_eff, pop, push, acc;
  logic [31:0]   redir_pc;
  logic [AW+1:0] reserved;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  assign mis_hit  = redirect_pc[1:0] != 2'b00;
  assign redir_pc = redirect_pc;
  assign misalign = rstd & misalign_q;
`else
  assign mis_hit  = 1'b0;
  assign redir_pc = redirect_pc & 32'hFFFF_FFFC;
  assign misalign = 1'b0;
`endif

  assign run     = (state_q == RUN);
  assign stop    = run & (halt | (redirect_valid & mis_hit));
  assign redir   = run & redirect_valid & ~halt & ~mis_hit;
  // Responses with nothing outstanding belong to requests discarded by reset.
  assign rsp_eff = imem_rsp_valid & (out_q != '0);

  assign ins_valid = rstd & run & (cnt_q != '0) & ~redir;
  assign pop       = ins_valid & ins_ready;

  // A same-cycle pop frees its slot, which keeps back-to-back issue at one per cycle.
  assign reserved       = {1'b0, out_q} + {1'b0, cnt_q} - {{(AW+1){1'b0}}, pop};
  assign imem_req_valid = rstd & run & ~halt & ~redirect_valid & (reserved < DEPTH);
  assign acc            = imem_req_valid & imem_req_ready;
  assign push           = rsp_eff & run & (drop_q == '0) & ~stop & ~redir;

  assign imem_addr = pc_q;
  assign ins       = ins_valid ? buf_ins_q[rd_q] : '0;
  assign ins_pc    = ins_valid ? buf_pc_q[rd_q]  : '0;
  assign halted    = rstd & (state_q == HALT);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    drop_d  = drop_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    pq_wr_d = pq_wr_q;
    pq_rd_d = pq_rd_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
    if (run & redirect_valid & mis_hit & ~halt) misalign_d = 1'b1;
`endif
    if (acc) begin
      pc_d    = pc_q + 32'd4;
      pq_wr_d = pq_wr_q + AW'(1);
    end
    if (rsp_eff) begin
      pq_rd_d = pq_rd_q + AW'(1);
      if (drop_q != '0) drop_d = drop_q - (AW+1)'(1);
    end
    out_d = out_q + (AW+1)'(acc) - (AW+1)'(rsp_eff);
    if (push) wr_d = wr_q + AW'(1);
    if (pop)  rd_d = rd_q + AW'(1);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    if (redir) begin
      // Everything still in flight was fetched down the old path.
      pc_d   = redir_pc;
      drop_d = out_d;
      cnt_d  = '0;
      wr_d   = '0;
      rd_d   = '0;
    end
    if (stop) begin
      state_d = HALT;
      cnt_d   = '0;
      wr_d    = '0;
      rd_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstd) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      out_q   <= '0;
      drop_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      pq_wr_q <= '0;
      pq_rd_q <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      pq_wr_q <= pq_wr_d;
      pq_rd_q <= pq_rd_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (acc) pcq_q[pq_wr_q] <= pc_q;
    if (push) begin
      buf_ins_q[wr_q] <= imem_rsp_data;
      buf_pc_q[wr_q]  <= pcq_q[pq_rd_q];
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with optional response stall, hand-derived expectations.
module tb_fetch_unit;
  localparam logic [31:0] MEM_XOR = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rstd;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        halted;
  logic        misalign;

  int          vectors     = 0;
  int          miscompares = 0;
  int          acc_cnt     = 0;
  int          acc_mark    = 0;
  bit          rsp_en      = 1'b1;
  logic [31:0] pend [$];

  fetch_unit #(.RESET_PC(32'h0000_8000), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .rstd           (rstd),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .ins            (ins),
    .ins_pc         (ins_pc),
    .halted         (halted),
    .misalign       (misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    vectors++;
    assert (obs === req) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, req);
    end
  endtask

  // Memory model: accepted addresses queue up and return one per cycle, starting the cycle after acceptance.
  task automatic tick();
    logic [31:0] a;
    @(negedge clk);
    if (imem_req_valid && imem_req_ready) begin
      pend.push_back(imem_addr);
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    if (rsp_en && pend.size() > 0) begin
      a = pend.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = a ^ MEM_XOR;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
  endtask

  task automatic do_reset();
    rstd = 1'b0;
    pend.delete();
    tick();
    tick();
  endtask

  task automatic release_rst();
    rstd    = 1'b1;
    acc_cnt = 0;
    #1;
  endtask

  initial begin
    rstd = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; ins_ready = 1'b1;

    // Reset values
    do_reset();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_ins_valid", 32'(ins_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_ins", ins, 32'd0);
    chk("rst_ins_pc", ins_pc, 32'd0);

    // Start-up latency and streaming
    release_rst();
    chk("c0_req_valid", 32'(imem_req_valid), 32'd1);
    chk("c0_addr", imem_addr, 32'h0000_8000);
    chk("c0_ins_valid", 32'(ins_valid), 32'd0);
    tick();
    chk("c1_addr", imem_addr, 32'h0000_8004);
    chk("c1_ins_valid", 32'(ins_valid), 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("stream_ins_valid", 32'(ins_valid), 32'd1);
      chk("stream_ins_pc", ins_pc, 32'h0000_8000 + 32'(4 * k));
      chk("stream_ins", ins, (32'h0000_8000 + 32'(4 * k)) ^ MEM_XOR);
      chk("stream_addr", imem_addr, 32'h0000_8008 + 32'(4 * k));
      tick();
    end

    // Decoder stall: credits cap the accepted requests, nothing is lost
    do_reset();
    ins_ready = 1'b0;
    release_rst();
    repeat (4) tick();
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_ins_valid", 32'(ins_valid), 32'd1);
    chk("stall_head_pc", ins_pc, 32'h0000_8000);
    tick();
    chk("stall_accepts", 32'(acc_cnt), 32'd2);
    ins_ready = 1'b1;
    #1;
    chk("unstall_ins_pc0", ins_pc, 32'h0000_8000);
    chk("unstall_req_valid", 32'(imem_req_valid), 32'd1);
    chk("unstall_addr", imem_addr, 32'h0000_8008);
    tick();
    chk("unstall_ins_pc1", ins_pc, 32'h0000_8004);
    tick();
    chk("unstall_ins_pc2", ins_pc, 32'h0000_8008);

    // Redirect with two requests in flight
    do_reset();
    rsp_en = 1'b0;
    release_rst();
    tick();
    tick();
    chk("rd_credit_block", 32'(imem_req_valid), 32'd0);
    chk("rd_inflight", 32'(acc_cnt), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    rsp_en         = 1'b1;
    #1;
    chk("rd_cycle_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rd_cycle_ins_valid", 32'(ins_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("rd_drop1_ins_valid", 32'(ins_valid), 32'd0);
    chk("rd_drop1_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    chk("rd_drop2_ins_valid", 32'(ins_valid), 32'd0);
    chk("rd_new_req_valid", 32'(imem_req_valid), 32'd1);
    chk("rd_new_addr", imem_addr, 32'h0000_0100);
    tick();
    chk("rd_wait_ins_valid", 32'(ins_valid), 32'd0);
    tick();
    chk("rd_first_valid", 32'(ins_valid), 32'd1);
    chk("rd_first_pc", ins_pc, 32'h0000_0100);
    chk("rd_first_ins", ins, 32'h0000_0100 ^ MEM_XOR);

    // Halt together with redirect: halt wins, PC frozen
    tick();
    halt           = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    #1;
    chk("halt_cycle_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    halt           = 1'b0;
    redirect_valid = 1'b0;
    #1;
    acc_mark = acc_cnt;
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_ins_valid", 32'(ins_valid), 32'd0);
    chk("halt_req_valid", 32'(imem_req_valid), 32'd0);
    chk("halt_pc", imem_addr, 32'h0000_010C);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("halt_hold_req_valid", 32'(imem_req_valid), 32'd0);
      chk("halt_hold_ins_valid", 32'(ins_valid), 32'd0);
      chk("halt_hold_halted", 32'(halted), 32'd1);
    end
    chk("halt_no_accepts", 32'(acc_cnt - acc_mark), 32'd0);

    // PC wrap at the top of the address space
    do_reset();
    rstd           = 1'b1;
    acc_cnt        = 0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    #1;
    chk("wrap_rd_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
    tick();
    chk("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr2", imem_addr, 32'h0000_0000);
    chk("wrap_pc0", ins_pc, 32'hFFFF_FFF8);
    tick();
    chk("wrap_pc1", ins_pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc2", ins_pc, 32'h0000_0000);
    chk("wrap_ins2", ins, 32'h0000_0000 ^ MEM_XOR);

    // Misaligned redirect while the FIFO holds an entry
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    #1;
    chk("mis_cycle_req_valid", 32'(imem_req_valid), 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("mis_trap_misalign", 32'(misalign), 32'd1);
    chk("mis_trap_halted", 32'(halted), 32'd1);
    chk("mis_trap_req_valid", 32'(imem_req_valid), 32'd0);
    chk("mis_trap_pc", imem_addr, 32'h0000_0008);
`else
    chk("mis_cycle_ins_valid", 32'(ins_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("mis_addr", imem_addr, 32'h0000_0100);
    chk("mis_req_valid", 32'(imem_req_valid), 32'd1);
    chk("mis_misalign", 32'(misalign), 32'd0);
    chk("mis_halted", 32'(halted), 32'd0);
    chk("mis_flushed", 32'(ins_valid), 32'd0);
    tick();
    chk("mis_wait_ins_valid", 32'(ins_valid), 32'd0);
    tick();
    chk("mis_first_valid", 32'(ins_valid), 32'd1);
    chk("mis_first_pc", ins_pc, 32'h0000_0100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decoder.
- Owns the PC and issues in-order word requests to instruction memory over a valid/ready request channel plus a valid-only response channel.
- Buffers fetched words with their PC in a small FIFO and presents them to the decoder with a valid/ready handshake.
- Handles redirects from branch/jump resolution, dropping stale in-flight responses, and a halt request raised by the decoder.

Parameters:
- RESET_PC, 32'h0000_8000, PC loaded on reset.
- BUF_DEPTH, 2, instruction FIFO entries; also the maximum in-flight requests (power of 2, 2..8).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstd  input  1  synchronous active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_addr  output  32  word-aligned fetch address.
- imem_rsp_valid  input  1  response word valid; responses are in order, at least 1 cycle after acceptance.
- imem_rsp_data  input  32  fetched instruction.
- redirect_valid  input  1  load new PC (taken branch, JAL, JALR).
- redirect_pc  input  32  redirect target.
- halt  input  1  stop fetching permanently (decoder halt flag).
- ins_valid  output  1  ins/ins_pc valid to decoder.
- ins_ready  input  1  decoder consumes entry.
- ins  output  32  instruction word.
- ins_pc  output  32  PC of ins.
- halted  output  1  fetch stopped.
- misalign  output  1  misaligned redirect flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (rstd=0 at a clock edge):
  - pc=RESET_PC; FIFO count=0; outstanding=0; drop_cnt=0; state=RUN.
  - Outputs: imem_req_valid=0, ins_valid=0, halted=0, misalign=0, ins=0, ins_pc=0.
  - While rstd=0, all outputs are held at these values.
  - Reset mid-operation discards all in-flight requests; responses arriving after reset release with outstanding=0 are ignored.
- States are RUN and HALT.
- RUN:
  - imem_req_valid=1 iff (outstanding + count) < BUF_DEPTH, and neither redirect_valid nor halt is asserted this cycle.
  - imem_addr=pc.
  - On accept (valid&ready): pc<=pc+4 with 32-bit wrap (FFFF_FFFC -> 0000_0000); outstanding+1.
- Response handling (imem_rsp_valid):
  - outstanding-1.
  - If drop_cnt>0: discard the word and decrement drop_cnt.
  - Otherwise push {resp_pc, word} into the FIFO. resp_pc comes from a parallel PC queue written at request acceptance.
- Output handshake:
  - ins_valid=(count>0); ins/ins_pc come from the FIFO head, driven from registers (no combinational path from imem_rsp to ins).
  - Pop when ins_valid&ins_ready.
  - Push and pop in the same cycle: count unchanged.
  - The FIFO never overflows, because the credit rule reserves space.
- Latency:
  - With single-cycle memory and ins_ready=1, the first ins_valid appears 2 cycles after reset release.
  - Sustained throughput is 1 instruction/cycle when BUF_DEPTH>=2.
- Redirect (redirect_valid=1 in RUN):
  - pc<=redirect_pc; FIFO flushed (count<=0).
  - drop_cnt<=outstanding after this cycle's accept/response accounting, so every request already issued is dropped.
  - No request issued that cycle; ins_valid forced 0 that cycle; a pop that cycle is ignored.
  - The first request to the new PC goes out in the next cycle.
- Halt (halt=1 in RUN):
  - state<=HALT; halted<=1 next cycle.
  - No further requests; FIFO flushed; ins_valid=0 from the next cycle.
  - halt and redirect in the same cycle: halt wins and the redirect is ignored.
- HALT:
  - Responses for in-flight requests are accepted and discarded.
  - redirect and halt inputs are ignored.
  - Only reset leaves HALT.
- redirect_pc[1:0] is forced to 2'b00 when the optional feature is absent.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined: a redirect with redirect_pc[1:0]!=0 sets misalign=1 (sticky until reset), enters HALT exactly as halt does, and leaves pc unchanged.
- Undefined: misalign is tied 0 and the low two bits of redirect_pc are cleared before loading pc.

Test Plan:
- Reset release, 1-cycle memory, ins_ready=1 -> imem_addr sequence 8000, 8004, 8008; ins_valid first high 2 cycles after release with ins_pc=8000; then one instruction per cycle.
- ins_ready=0 for 5 cycles -> at most BUF_DEPTH requests accepted; count saturates at 2 with no loss; on release, ins_pc continues 8000, 8004 in order.
- Redirect to 0000_0100 with 2 requests in flight -> both stale responses dropped; next ins_pc=0100 with no 8xxx PC appearing after the redirect.
- halt asserted with redirect_valid in the same cycle -> halted=1 next cycle; no further imem_req_valid; ins_valid stays 0; pc unchanged.
- pc=FFFF_FFFC -> next imem_addr 0000_0000.
- With FETCH_MISALIGN_TRAP_EN defined, redirect_pc=0000_0102 -> misalign=1 and halted=1; without the macro, the next request goes to 0000_0100.
